// File: rtl/sad_block_mem.sv
// A/B block store answering the SAD datapath's AB_addr with combinational A_data/B_data.
// Optional feature macro: DOUBLE_BUF_EN (two banks so a load overlaps a SAD run on the other bank).
module sad_block_mem #(
  parameter int DEPTH = 256,
  parameter int DW    = 8,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          blk_valid,
  input  logic          blk_release,
  input  logic [AW-1:0] AB_addr,
  output logic [DW-1:0] A_data,
  output logic [DW-1:0] B_data,
  output logic          ld_done
);

  localparam int LW = $clog2(DEPTH);
`ifdef DOUBLE_BUF_EN
  localparam int NB = 2;
  localparam int IW = LW + 1;
`else
  localparam int NB = 1;
  localparam int IW = LW;
`endif

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  logic [1:0]    r_state;
  logic [LW-1:0] r_wr_cnt;
  logic          r_ld_done;
  logic [DW-1:0] r_mem_a [0:NB*DEPTH-1];
  logic [DW-1:0] r_mem_b [0:NB*DEPTH-1];

  logic          w_xfer;
  logic          w_cnt_last;
  logic          w_last;
  logic          w_release;
  logic          w_goto_full;
  logic          w_rd_ok;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_xfer     = ld_valid & ld_ready & ~rst;
  assign w_cnt_last = (r_wr_cnt == LW'(DEPTH - 1));
  assign w_last     = w_xfer & w_cnt_last & (r_state == S_LOAD_B);
  assign w_release  = blk_release & blk_valid;

`ifdef DOUBLE_BUF_EN
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] r_bank_full;
  logic [1:0] w_bank_full_next;

  // Completion and release may hit different banks in the same cycle; both apply.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign w_bank_full_next[gi] =
        (r_bank_full[gi] & ~(w_release & (r_rd_bank == 1'(gi)))) |
        (w_last & (r_wr_bank == 1'(gi)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= w_bank_full_next;
      if (w_last)
        r_wr_bank <= ~r_wr_bank;
      if (w_release)
        r_rd_bank <= ~r_rd_bank;
    end
  end

  assign ld_ready    = ~r_bank_full[r_wr_bank];
  assign blk_valid   = r_bank_full[r_rd_bank];
  assign w_goto_full = &w_bank_full_next;
  assign w_wr_idx    = {r_wr_bank, r_wr_cnt};
  assign w_rd_idx    = {r_rd_bank, AB_addr[LW-1:0]};
`else
  assign ld_ready    = (r_state != S_FULL);
  assign blk_valid   = (r_state == S_FULL);
  assign w_goto_full = 1'b1;
  assign w_wr_idx    = r_wr_cnt;
  assign w_rd_idx    = AB_addr[LW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LOAD_A;
      r_wr_cnt  <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_ld_done <= w_last;
      if (w_xfer)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      case (r_state)
        S_LOAD_A: if (w_xfer && w_cnt_last) r_state <= S_LOAD_B;
        S_LOAD_B: if (w_last) r_state <= w_goto_full ? S_FULL : S_LOAD_A;
        S_FULL:   if (w_release) r_state <= S_LOAD_A;
        default:  r_state <= S_LOAD_A;
      endcase
    end
  end

  // Storage has no reset; contents are only visible once blk_valid is set.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      if (r_state == S_LOAD_A)
        r_mem_a[w_wr_idx] <= ld_data;
      else
        r_mem_b[w_wr_idx] <= ld_data;
    end
  end

  // Overflow address (loop exit) and an unreadable pair both return zero.
  assign w_rd_ok = blk_valid & ~AB_addr[AW-1];
  assign A_data  = w_rd_ok ? r_mem_a[w_rd_idx] : '0;
  assign B_data  = w_rd_ok ? r_mem_b[w_rd_idx] : '0;
  assign ld_done = r_ld_done;

endmodule

// File: tb/tb_sad_block_mem.sv
// Scoreboard bench for sad_block_mem: stimulus queues expected reads/ld_done, a monitor checks them.
module tb_sad_block_mem;
  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       blk_valid;
  logic       blk_release;
  logic [8:0] AB_addr;
  logic [7:0] A_data;
  logic [7:0] B_data;
  logic       ld_done;

  sad_block_mem #(.DEPTH(256), .DW(8), .AW(9)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .blk_valid(blk_valid), .blk_release(blk_release), .AB_addr(AB_addr),
    .A_data(A_data), .B_data(B_data), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

`ifdef DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  typedef struct {
    logic [8:0] addr;
    logic [7:0] a;
    logic [7:0] b;
  } rd_exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nxfer = 0;
  bit rd_strobe = 1'b0;
  rd_exp_t rd_q[$];
  int done_q[$];
  rd_exp_t mon_e;
  int mon_c;
  logic [7:0] pat_a[256];
  logic [7:0] pat_b[256];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ld_valid && ld_ready && !rst) nxfer = nxfer + 1;
  end

  // Monitor: pops expectations whenever a read is presented or ld_done pulses.
  always @(negedge clk) begin
    if (rd_strobe) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected addr=%0d", AB_addr);
      end else begin
        mon_e = rd_q.pop_front();
        if (A_data !== mon_e.a || B_data !== mon_e.b) begin
          bad++;
          $display("FAIL rd addr=%0d got A=%02h B=%02h want A=%02h B=%02h",
                   mon_e.addr, A_data, B_data, mon_e.a, mon_e.b);
        end else
          $display("rd addr=%0d A=%02h B=%02h ok", mon_e.addr, A_data, B_data);
      end
    end
    if (ld_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL ld_done_unexpected cyc=%0d", cyc);
      end else begin
        mon_c = done_q.pop_front();
        if (cyc != mon_c) begin
          bad++;
          $display("FAIL ld_done_cycle got=%0d want=%0d", cyc, mon_c);
        end else
          $display("ld_done at cyc=%0d ok", cyc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end else
      $display("chk %s=%0h ok", name, act);
  endtask

  task automatic set_pat(input int mode, input logic [7:0] va, input logic [7:0] vb);
    for (int i = 0; i < 256; i++) begin
      pat_a[i] = (mode == 0) ? 8'(i) : va;
      pat_b[i] = (mode == 0) ? 8'(255 - i) : vb;
    end
  endtask

  task automatic rd(input logic [8:0] a, input logic [7:0] ea, input logic [7:0] eb);
    rd_exp_t e;
    @(posedge clk); #1;
    AB_addr = a;
    e.addr = a; e.a = ea; e.b = eb;
    rd_q.push_back(e);
    rd_strobe = 1'b1;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic pulse_release();
    @(posedge clk); #1;
    blk_release = 1'b1;
    @(posedge clk); #1;
    blk_release = 1'b0;
  endtask

  // Streams bytes from pat_a/pat_b; ends at posedge+1 right after the last accepted byte.
  task automatic load(input bit gapped, input int limit, input bit rel_last);
    int idx = 0;
    int guard = 0;
    bit v;
    bit rdy;
    @(posedge clk); #1;
    while (idx < limit && guard < 4000) begin
      rdy = ld_ready;
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_valid = v;
      ld_data = (idx < 256) ? pat_a[idx] : pat_b[idx - 256];
      if (v && rdy) begin
        idx++;
        if (idx == 512) done_q.push_back(cyc + 1);
        if (idx == limit && rel_last) blk_release = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    ld_valid = 1'b0;
    blk_release = 1'b0;
    if (guard >= 4000) begin
      total++; bad++;
      $display("FAIL load_timeout got=%0d want=%0d", idx, limit);
    end
  endtask

  int n0;

  initial begin
    rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h5A; blk_release = 1'b0; AB_addr = '0;
    // T1: reset held 2 cycles with ld_valid asserted
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("rst_ld_ready", int'(ld_ready), 1);
    chk("rst_blk_valid", int'(blk_valid), 0);
    chk("rst_ld_done", int'(ld_done), 0);
    chk("rst_A_data", int'(A_data), 0);
    chk("rst_B_data", int'(B_data), 0);

    // T2: straight load A[i]=i, B[i]=255-i
    set_pat(0, 8'h00, 8'h00);
    n0 = nxfer;
    load(1'b0, 512, 1'b0);
    @(negedge clk);
    chk("t2_xfers", nxfer - n0, 512);
    chk("t2_blk_valid", int'(blk_valid), 1);
    chk("t2_ld_ready", int'(ld_ready), DB ? 1 : 0);
    rd(9'd0, 8'h00, 8'hFF);
    rd(9'd200, 8'hC8, 8'h37);
    rd(9'd256, 8'h00, 8'h00);
    rd(9'd255, 8'hFF, 8'h00);
`ifndef DOUBLE_BUF_EN
    // Bytes offered while full must be refused and not stored
    n0 = nxfer;
    ld_valid = 1'b1; ld_data = 8'hEE;
    repeat (4) begin
      @(negedge clk);
      chk("full_ld_ready", int'(ld_ready), 0);
    end
    ld_valid = 1'b0;
    chk("full_no_xfer", nxfer - n0, 0);
    rd(9'd17, 8'h11, 8'hEE);
`endif

    // T4 release then T3 gapped reload of the same pattern
    pulse_release();
    @(negedge clk);
    chk("rel_blk_valid", int'(blk_valid), 0);
    chk("rel_ld_ready", int'(ld_ready), 1);
    rd(9'd5, 8'h00, 8'h00);
    n0 = nxfer;
    load(1'b1, 512, 1'b0);
    @(negedge clk);
    chk("t3_xfers", nxfer - n0, 512);
    chk("t3_blk_valid", int'(blk_valid), 1);
    rd(9'd0, 8'h00, 8'hFF);
    rd(9'd77, 8'h4D, 8'hB2);
    rd(9'd200, 8'hC8, 8'h37);
    rd(9'd256, 8'h00, 8'h00);

    // T4: release, spurious release in LOAD_A, reload with 0x11
    pulse_release();
    pulse_release();
    @(negedge clk);
    chk("spur_blk_valid", int'(blk_valid), 0);
    chk("spur_ld_ready", int'(ld_ready), 1);
    set_pat(1, 8'h11, 8'h11);
    n0 = nxfer;
    load(1'b0, 512, 1'b0);
    @(negedge clk);
    chk("t4_xfers", nxfer - n0, 512);
    rd(9'd5, 8'h11, 8'h11);

    // T5: reset after 300 transfers, then a full AA/55 pair
    pulse_release();
    set_pat(1, 8'h77, 8'h77);
    load(1'b0, 300, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_blk_valid", int'(blk_valid), 0);
    chk("t5_ld_ready", int'(ld_ready), 1);
    set_pat(1, 8'hAA, 8'h55);
    n0 = nxfer;
    load(1'b0, 512, 1'b0);
    @(negedge clk);
    chk("t5_xfers", nxfer - n0, 512);
    chk("t5_blk_valid_full", int'(blk_valid), 1);
    for (int i = 0; i < 256; i++) rd(9'(i), 8'hAA, 8'h55);
    rd(9'd256, 8'h00, 8'h00);

`ifdef DOUBLE_BUF_EN
    // T6: P1 completes in the same cycle P0 is released
    set_pat(1, 8'h3C, 8'hC3);
    load(1'b0, 512, 1'b1);
    @(negedge clk);
    chk("t6_blk_valid", int'(blk_valid), 1);
    chk("t6_ld_ready", int'(ld_ready), 1);
    rd(9'd9, 8'h3C, 8'hC3);
    set_pat(1, 8'h21, 8'h12);
    load(1'b0, 512, 1'b0);
    @(negedge clk);
    chk("t6_both_full_ld_ready", int'(ld_ready), 0);
    chk("t6_both_full_blk_valid", int'(blk_valid), 1);
    rd(9'd9, 8'h3C, 8'hC3);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d want=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
